demux1to4_stream: RTL and testbench

- 1-to-4 routing stage for 128-bit data words (AES state/key blocks). It sits at the output side of the datapath and splits the single result stream into four consumer channels.
- A word is steered to a channel by either an explicit select or an internal round-robin pointer.
- Each channel has a one-entry output register with valid/ready handshake, so a stalled consumer blocks only words aimed at it.

---
 rtl/demux1to4_stream.sv | 48 ++++
 tb/tb_demux1to4_stream.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/demux1to4_stream.sv
// 1-to-4 word router (in_sel or round-robin target), one-entry register per channel, 1-cycle latency.
// Backpressure is per channel: in_ready drops only while the chosen target is full and not draining.
module demux1to4_stream #(
    parameter int WIDTH = 128,
    parameter int NCH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [1:0]             in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mode,
    output logic [NCH*WIDTH-1:0]   out_data,
    output logic [NCH-1:0]         out_valid,
    input  logic [NCH-1:0]         out_ready,
    output logic [1:0]             rr_ptr
);

    logic [1:0] tgt;
    logic       accept;

    assign tgt      = mode ? rr_ptr : in_sel;
    // A full channel may still take a word in the same cycle it drains.
    assign in_ready = !reset && (!out_valid[tgt] || out_ready[tgt]);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= '0;
            rr_ptr    <= 2'd0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (accept && (tgt == 2'(k))) begin
                    out_data[k*WIDTH +: WIDTH] <= in_data;
                    out_valid[k]               <= 1'b1;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
            if (accept && mode) begin
                rr_ptr <= rr_ptr + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_demux1to4_stream.sv
// Randomized and directed checks of demux1to4_stream against a per-channel behavioural model.
module tb_demux1to4_stream;
    localparam int WIDTH = 128;
    localparam int NCH   = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [WIDTH-1:0]     in_data;
    logic [1:0]           in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic                 mode;
    logic [NCH*WIDTH-1:0] out_data;
    logic [NCH-1:0]       out_valid;
    logic [NCH-1:0]       out_ready;
    logic [1:0]           rr_ptr;

    demux1to4_stream #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .rr_ptr(rr_ptr)
    );

    always #5 clk = ~clk;

    int ncmp  = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    // Behavioural model: what each channel holds, and the round-robin position.
    logic [WIDTH-1:0] m_data [NCH];
    bit               m_valid[NCH];
    int               m_ptr;

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_tgt();
        return mode ? m_ptr : int'(in_sel);
    endfunction

    function automatic bit m_rdy();
        int t;
        t = m_tgt();
        return !reset && (!m_valid[t] || out_ready[t]);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                m_valid[k] = 1'b0;
                m_data[k]  = '0;
            end
            m_ptr = 0;
        end else begin
            int  t;
            bit  acc;
            t   = m_tgt();
            acc = in_valid && m_rdy();
            for (int k = 0; k < NCH; k++) begin
                if (acc && t == k) begin
                    m_data[k]  = in_data;
                    m_valid[k] = 1'b1;
                end else if (m_valid[k] && out_ready[k]) begin
                    m_valid[k] = 1'b0;
                end
            end
            if (acc && mode) m_ptr = (m_ptr + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", WIDTH'(in_ready), WIDTH'(m_rdy()));
            chk("rr_ptr", WIDTH'(rr_ptr), WIDTH'(m_ptr));
            for (int k = 0; k < NCH; k++) begin
                chk($sformatf("out_valid[%0d]", k), WIDTH'(out_valid[k]), WIDTH'(m_valid[k]));
                chk($sformatf("out_data[%0d]", k), out_data[k*WIDTH +: WIDTH], m_data[k]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [WIDTH-1:0] w1, w2;
    logic [WIDTH-1:0] rrw[6];
    int               rrch[6];

    initial begin
        reset = 1'b1; in_valid = 1'b1; out_ready = 4'b1111; mode = 1'b0;
        in_sel = 2'd0; in_data = rnd_word();
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst out_valid", WIDTH'(out_valid), WIDTH'(4'b0000));
        chk("rst rr_ptr", WIDTH'(rr_ptr), WIDTH'(2'd0));
        chk("rst out_data", out_data[WIDTH-1:0] | out_data[3*WIDTH +: WIDTH], '0);
        chk("rst in_ready", WIDTH'(in_ready), WIDTH'(1'b0));
        reset = 1'b0; in_valid = 1'b0;
        #1 chk("post-rst in_ready", WIDTH'(in_ready), WIDTH'(1'b1));

        // Directed routing into channel 2 with all consumers stalled.
        w1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        out_ready = 4'b0000; mode = 1'b0; in_sel = 2'd2; in_data = w1; in_valid = 1'b1;
        cyc();
        chk("dir out_valid", WIDTH'(out_valid), WIDTH'(4'b0100));
        chk("dir out_data2", out_data[2*WIDTH +: WIDTH], w1);
        in_data = rnd_word();
        #1 chk("dir full in_ready", WIDTH'(in_ready), WIDTH'(1'b0));
        cyc();
        chk("dir hold data2", out_data[2*WIDTH +: WIDTH], w1);

        // Channel 2 stalled must not block channel 1.
        w2 = rnd_word();
        in_sel = 2'd1; in_data = w2;
        #1 chk("iso in_ready", WIDTH'(in_ready), WIDTH'(1'b1));
        cyc();
        chk("iso out_valid", WIDTH'(out_valid), WIDTH'(4'b0110));
        in_valid = 1'b0; out_ready = 4'b0100;
        cyc();
        chk("iso drain2", WIDTH'(out_valid), WIDTH'(4'b0010));
        out_ready = 4'b1111;
        cyc();

        // Back-to-back words into channel 3.
        in_sel = 2'd3;
        for (int i = 1; i <= 8; i++) begin
            in_data = WIDTH'(i); in_valid = 1'b1;
            #1 chk("thru in_ready", WIDTH'(in_ready), WIDTH'(1'b1));
            cyc();
            chk("thru data3", out_data[3*WIDTH +: WIDTH], WIDTH'(i));
            chk("thru valid3", WIDTH'(out_valid[3]), WIDTH'(1'b1));
        end
        in_valid = 1'b0;
        cyc();

        // Round-robin wrap from pointer 0.
        mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rrw[i] = rnd_word(); rrch[i] = i % 4;
            in_data = rrw[i]; in_sel = 2'($urandom_range(0, 3)); in_valid = 1'b1;
            cyc();
            chk("rr valid", WIDTH'(out_valid[rrch[i]]), WIDTH'(1'b1));
            chk("rr data", out_data[rrch[i]*WIDTH +: WIDTH], rrw[i]);
        end
        chk("rr ptr end", WIDTH'(rr_ptr), WIDTH'(2'd2));
        mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_data = rnd_word(); in_sel = 2'($urandom_range(0, 3));
            cyc();
        end
        chk("rr ptr kept", WIDTH'(rr_ptr), WIDTH'(2'd2));

        // Advance pointer 2 -> 1, then fill channel 1 and stall it.
        mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = rnd_word();
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        out_ready = 4'b0000; mode = 1'b0; in_sel = 2'd1; in_data = rnd_word(); in_valid = 1'b1;
        cyc();
        mode = 1'b1; in_data = rnd_word();
        #1;
        chk("stall in_ready", WIDTH'(in_ready), WIDTH'(1'b0));
        chk("stall rr_ptr", WIDTH'(rr_ptr), WIDTH'(2'd1));
        chk("stall out_valid", WIDTH'(out_valid), WIDTH'(4'b0010));
        cyc();
        reset = 1'b1;
        cyc();
        chk("midrst out_valid", WIDTH'(out_valid), WIDTH'(4'b0000));
        chk("midrst rr_ptr", WIDTH'(rr_ptr), WIDTH'(2'd0));
        reset = 1'b0; in_valid = 1'b0; out_ready = 4'b1111;
        cyc();
        chk("midrst no emit", WIDTH'(out_valid), WIDTH'(4'b0000));

        // Random traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = rnd_word();
            mode      = ($urandom_range(0, 2) == 0);
            out_ready = 4'($urandom);
            cyc();
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
        $finish;
    end
endmodule
